icache_sa_controller: RTL and testbench

//   Set-associative instruction cache for the SM fetch stage. Replaces the direct-mapped, single-word-line design.

---
 rtl/icache_sa_if.sv | 24 ++
 rtl/icache_sa_controller.sv | 165 ++++++++++++++++
 tb/tb_icache_sa_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch request/response and refill-memory handshake bundle for icache_sa_controller.
interface icache_sa_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    modport master (
        output req_valid, req_addr, flush, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_req, mem_addr
    );
    modport slave (
        input  req_valid, req_addr, flush, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_sa_controller.sv
// icache_sa_controller: set-associative instruction cache with multi-beat refill, round-robin replacement and flush.
// Defining ICACHE_PERF_CNT_EN adds saturating perf_hits/perf_misses counters.
module icache_sa_controller #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic clk,
    input  logic rst,
    icache_sa_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);
    localparam int WB    = $clog2(DATA_W / 8);
    localparam int OB    = $clog2(LINE_BYTES);
    localparam int IB    = $clog2(SETS);
    localparam int TW    = ADDR_W - OB - IB;
    localparam int BEATS = LINE_BYTES * 8 / DATA_W;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, RESP, FLUSH} state_t;

    state_t            state;
    logic              ready_q;
    logic              flush_p;
    logic [BW-1:0]     cnt;
    logic [IB-1:0]     l_idx;
    logic [TW-1:0]     l_tag;
    logic [BW-1:0]     l_word;
    logic [WW-1:0]     l_way;
    logic              l_evict;
    logic [WAYS-1:0]   valid [SETS];
    logic [WW-1:0]     rr    [SETS];
    logic [TW-1:0]     tags  [SETS][WAYS];
    logic [DATA_W-1:0] lines [SETS][WAYS][BEATS];

    logic [IB-1:0] r_idx;
    logic [TW-1:0] r_tag;
    logic [BW-1:0] r_word;
    logic          hit, inv, last_ack;
    logic [WW-1:0] hit_way, inv_way, victim;

    assign r_idx     = bus.req_addr[OB+IB-1:OB];
    assign r_tag     = bus.req_addr[ADDR_W-1:OB+IB];
    assign r_word    = BEATS == 1 ? '0 : BW'(bus.req_addr >> WB);
    assign victim    = inv ? inv_way : rr[r_idx];
    assign last_ack  = state == REFILL && bus.mem_ack && cnt == BW'(BEATS - 1);
    // flush in IDLE must block acceptance in the same cycle, so ready is gated combinationally
    assign bus.req_ready = ready_q & ~bus.flush;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv     = 1'b0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid[r_idx][i] && tags[r_idx][i] == r_tag) begin
                hit     = 1'b1;
                hit_way = WW'(i);
            end
            if (!valid[r_idx][i]) begin
                inv     = 1'b1;
                inv_way = WW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && bus.mem_ack)
            lines[l_idx][l_way][cnt] <= bus.mem_rdata;
        if (last_ack)
            tags[l_idx][l_way] <= l_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            flush_p      <= 1'b0;
            cnt          <= '0;
            l_idx        <= '0;
            l_tag        <= '0;
            l_word       <= '0;
            l_way        <= '0;
            l_evict      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                rr[s]    <= '0;
            end
`ifdef ICACHE_PERF_CNT_EN
            perf_hits   <= '0;
            perf_misses <= '0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        state   <= FLUSH;
                        ready_q <= 1'b0;
                    end else if (bus.req_valid && hit) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= lines[r_idx][hit_way][r_word];
`ifdef ICACHE_PERF_CNT_EN
                        perf_hits <= perf_hits + {31'd0, perf_hits != '1};
`endif
                    end else if (bus.req_valid) begin
                        state        <= REFILL;
                        ready_q      <= 1'b0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {bus.req_addr[ADDR_W-1:OB], OB'(0)};
                        cnt          <= '0;
                        l_idx        <= r_idx;
                        l_tag        <= r_tag;
                        l_word       <= r_word;
                        l_way        <= victim;
                        l_evict      <= ~inv;
`ifdef ICACHE_PERF_CNT_EN
                        perf_misses <= perf_misses + {31'd0, perf_misses != '1};
`endif
                    end
                end
                REFILL: begin
                    if (bus.flush)
                        flush_p <= 1'b1;
                    if (bus.mem_ack)
                        cnt <= cnt + 1'b1;
                    if (last_ack) begin
                        state               <= RESP;
                        cnt                 <= '0;
                        bus.mem_req         <= 1'b0;
                        valid[l_idx][l_way] <= 1'b1;
                        rr[l_idx]           <= l_evict ? WW'((int'(rr[l_idx]) + 1) % WAYS) : rr[l_idx];
                        bus.rsp_valid       <= 1'b1;
                        bus.rsp_data        <= l_word == cnt ? bus.mem_rdata : lines[l_idx][l_way][l_word];
                    end
                end
                RESP: begin
                    state   <= (flush_p | bus.flush) ? FLUSH : IDLE;
                    ready_q <= ~(flush_p | bus.flush);
                    flush_p <= 1'b0;
                end
                FLUSH: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    for (int s = 0; s < SETS; s++) begin
                        valid[s] <= '0;
                        rr[s]    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_sa_controller.sv
// tb_icache_sa_controller: directed checks of hit/miss, replacement, flush and reset behaviour.
module tb_icache_sa_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    icache_sa_if #(.ADDR_W(32), .DATA_W(64)) bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    icache_sa_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hits(perf_hits),
        .perf_misses(perf_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        #1;
        chk("req_ready_on_issue", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // memory model: each beat carries DEADBEEF in the top half and its own byte address below
    task automatic serve(input int first, input int last, input int flush_beat);
        for (int b = first; b <= last; b++) begin
            chk("mem_req_during_refill", bus.mem_req, 1);
            chk("no_rsp_during_refill", bus.rsp_valid, 0);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 64'hDEADBEEF_0000_0000 | 64'(bus.mem_addr + 32'(b * 8));
            bus.flush     = (b == flush_beat);
            tick();
            bus.mem_ack   = 1'b0;
            bus.flush     = 1'b0;
        end
    endtask

    task automatic miss(input logic [31:0] addr, input logic [31:0] base, input logic [63:0] exp);
        issue(addr);
        chk("miss_mem_req", bus.mem_req, 1);
        chk("miss_mem_addr", bus.mem_addr, base);
        chk("miss_req_ready_low", bus.req_ready, 0);
        serve(0, 7, -1);
        chk("miss_rsp_valid", bus.rsp_valid, 1);
        chk("miss_rsp_data", bus.rsp_data, exp);
        chk("miss_mem_req_dropped", bus.mem_req, 0);
        tick();
        chk("back_to_idle_ready", bus.req_ready, 1);
    endtask

    task automatic hit(input logic [31:0] addr, input logic [63:0] exp);
        issue(addr);
        chk("hit_rsp_valid", bus.rsp_valid, 1);
        chk("hit_rsp_data", bus.rsp_data, exp);
        chk("hit_no_mem_req", bus.mem_req, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;
        tick();

        // cold miss, then a stray ack in IDLE must not disturb anything
        miss(32'h1008, 32'h1000, 64'hDEADBEEF_0000_1008);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
        tick();
        bus.mem_ack   = 1'b0;
        chk("stray_ack_no_rsp", bus.rsp_valid, 0);
        chk("stray_ack_no_req", bus.mem_req, 0);
        hit(32'h1010, 64'hDEADBEEF_0000_1010);
        tick();
        chk("hit_single_pulse", bus.rsp_valid, 0);

        // back-to-back hits
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1000;
        tick();
        chk("b2b0_valid", bus.rsp_valid, 1);
        chk("b2b0_data", bus.rsp_data, 64'hDEADBEEF_0000_1000);
        bus.req_addr = 32'h1008;
        tick();
        chk("b2b1_valid", bus.rsp_valid, 1);
        chk("b2b1_data", bus.rsp_data, 64'hDEADBEEF_0000_1008);
        bus.req_addr = 32'h1010;
        tick();
        chk("b2b2_valid", bus.rsp_valid, 1);
        chk("b2b2_data", bus.rsp_data, 64'hDEADBEEF_0000_1010);
        bus.req_valid = 1'b0;
        tick();
        chk("b2b_end", bus.rsp_valid, 0);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_misses", perf_misses, 1);
        chk("perf_hits", perf_hits, 4);
`endif

        // flush in IDLE beats a simultaneous request
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1000;
        bus.flush     = 1'b1;
        #1;
        chk("flush_blocks_ready", bus.req_ready, 0);
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        chk("flush_no_rsp", bus.rsp_valid, 0);
        chk("flush_no_mem_req", bus.mem_req, 0);
        chk("flush_state_not_ready", bus.req_ready, 0);
        tick();
        chk("after_flush_ready", bus.req_ready, 1);

        // conflict in set 0: 0x2000 evicts way 0 (0x0000)
        miss(32'h0000, 32'h0000, 64'hDEADBEEF_0000_0000);
        miss(32'h1018, 32'h1000, 64'hDEADBEEF_0000_1018);
        miss(32'h2020, 32'h2000, 64'hDEADBEEF_0000_2020);
        hit(32'h1000, 64'hDEADBEEF_0000_1000);
        miss(32'h0008, 32'h0000, 64'hDEADBEEF_0000_0008);
        hit(32'h2000, 64'hDEADBEEF_0000_2000);

        // flush during beat 4 of a refill
        issue(32'h3008);
        chk("fl_mem_addr", bus.mem_addr, 32'h3000);
        serve(0, 7, 4);
        chk("fl_rsp_valid", bus.rsp_valid, 1);
        chk("fl_rsp_data", bus.rsp_data, 64'hDEADBEEF_0000_3008);
        tick();
        chk("fl_flush_state", bus.req_ready, 0);
        chk("fl_flush_no_rsp", bus.rsp_valid, 0);
        tick();
        chk("fl_idle_again", bus.req_ready, 1);
        miss(32'h3008, 32'h3000, 64'hDEADBEEF_0000_3008);
        miss(32'h2000, 32'h2000, 64'hDEADBEEF_0000_2000);

        // async reset mid-refill
        issue(32'h5010);
        chk("rr_mem_addr", bus.mem_addr, 32'h5000);
        serve(0, 2, -1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_req", bus.mem_req, 0);
        chk("async_rst_ready", bus.req_ready, 1);
        chk("async_rst_mem_addr", bus.mem_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        miss(32'h5010, 32'h5000, 64'hDEADBEEF_0000_5010);
        hit(32'h5038, 64'hDEADBEEF_0000_5038);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
